// File: rtl/alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_seq
// Description : N-bit SM83-style ALU evaluated serially, one nibble per
//               cycle (LSB first). Produces a result and {Z,N,H,C} flags for
//               ADD/ADC/SUB/SBC/AND/XOR/OR/CP behind a start/busy/done
//               handshake.
//               Optional feature macro: ALU_NIBBLE_DAA_EN (adds a one-cycle
//               FIX state that applies SM83 DAA when daa=1 at accept).
// Revision    : 1.0  initial release
// ============================================================================
module alu_nibble_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             daa,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags_out
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [KW-1:0] c_K_LAST = KW'(NIBBLES - 1);
    // The nibble whose carry-out is the half-carry (carry out of bit WIDTH-5)
    localparam logic [KW-1:0] c_K_HALF = KW'(NIBBLES - 2);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_ADC = 3'd1;
    localparam logic [2:0] c_OP_SUB = 3'd2;
    localparam logic [2:0] c_OP_SBC = 3'd3;
    localparam logic [2:0] c_OP_AND = 3'd4;
    localparam logic [2:0] c_OP_XOR = 3'd5;
    localparam logic [2:0] c_OP_OR  = 3'd6;
    localparam logic [2:0] c_OP_CP  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [KW-1:0]      r_k;
    logic               r_cy;
    logic               r_h;
    logic [WIDTH-1:0]   r_acc;

    logic               w_accept;
    logic               w_cin0;
    logic               w_sub;
    logic [3:0]         w_an;
    logic [3:0]         w_bn;
    logic [3:0]         w_bx;
    logic [4:0]         w_sum;
    logic [3:0]         w_nib;
    logic               w_cout;
    logic [WIDTH-1:0]   w_full;
    logic [WIDTH-1:0]   w_src;
    logic               w_csrc;
    logic               w_zero;
    logic [WIDTH-1:0]   w_res;
    logic [3:0]         w_flags;
    logic               w_unused;

`ifdef ALU_NIBBLE_DAA_EN
    logic               r_daa;
    logic [2:0]         r_fnhc;     // latched {N,H,C} for the decimal adjust
    logic [7:0]         w_daa_adj;
    logic [7:0]         w_daa_byte;
    logic               w_daa_c;
    logic [WIDTH-1:0]   w_daa_res;

    assign w_unused = flags_in[3];
`else
    assign w_unused = ^{daa, flags_in[3:1]};
`endif

    // A new operation is taken only when nothing is in flight
    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    // State register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
`ifdef ALU_NIBBLE_DAA_EN
                if (r_k == c_K_LAST) w_state_nx = S_FIX;
`else
                if (r_k == c_K_LAST) w_state_nx = S_DONE;
`endif
            end
`ifdef ALU_NIBBLE_DAA_EN
            S_FIX: begin
                busy       = 1'b1;
                w_state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Carry into nibble 0: subtraction is a + ~b + ~borrow_in
    always_comb begin
        w_cin0 = 1'b0;
        case (op)
            c_OP_ADC: w_cin0 = flags_in[0];
            c_OP_SUB: w_cin0 = 1'b1;
            c_OP_CP:  w_cin0 = 1'b1;
            c_OP_SBC: w_cin0 = ~flags_in[0];
            default:  w_cin0 = 1'b0;
        endcase
    end

    // One 4-bit slice of the serial datapath
    always_comb begin
        w_sub  = (r_op == c_OP_SUB) | (r_op == c_OP_SBC) | (r_op == c_OP_CP);
        w_an   = r_a[{r_k, 2'b00} +: 4];
        w_bn   = r_b[{r_k, 2'b00} +: 4];
        w_bx   = w_sub ? ~w_bn : w_bn;
        w_sum  = {1'b0, w_an} + {1'b0, w_bx} + {4'b0000, r_cy};
        w_cout = w_sum[4];
        case (r_op)
            c_OP_AND: w_nib = w_an & w_bn;
            c_OP_XOR: w_nib = w_an ^ w_bn;
            c_OP_OR:  w_nib = w_an | w_bn;
            default:  w_nib = w_sum[3:0];
        endcase
        w_full                    = r_acc;
        w_full[{r_k, 2'b00} +: 4] = w_nib;
    end

    // Final result/flags; in RUN the last nibble is merged combinationally,
    // in FIX everything is already registered
    always_comb begin
        w_src   = (r_state == S_RUN) ? w_full : r_acc;
        w_csrc  = (r_state == S_RUN) ? w_cout : r_cy;
        w_zero  = (w_src == '0);
        w_res   = w_src;
        w_flags = 4'b0000;
        case (r_op)
            c_OP_ADD, c_OP_ADC: w_flags = {w_zero, 1'b0, r_h, w_csrc};
            c_OP_SUB, c_OP_SBC: w_flags = {w_zero, 1'b1, ~r_h, ~w_csrc};
            c_OP_CP: begin
                w_flags = {w_zero, 1'b1, ~r_h, ~w_csrc};
                w_res   = r_a;
            end
            c_OP_AND: w_flags = {w_zero, 1'b0, 1'b1, 1'b0};
            default:  w_flags = {w_zero, 1'b0, 1'b0, 1'b0};
        endcase
`ifdef ALU_NIBBLE_DAA_EN
        w_daa_adj = 8'h00;
        if (!r_fnhc[2]) begin
            if (r_fnhc[1] || (r_a[3:0] > 4'd9)) w_daa_adj = w_daa_adj | 8'h06;
            w_daa_c = r_fnhc[0] || (r_a[7:0] > 8'h99);
            if (w_daa_c) w_daa_adj = w_daa_adj | 8'h60;
            w_daa_byte = r_a[7:0] + w_daa_adj;
        end else begin
            if (r_fnhc[1]) w_daa_adj = w_daa_adj | 8'h06;
            if (r_fnhc[0]) w_daa_adj = w_daa_adj | 8'h60;
            w_daa_c    = r_fnhc[0];
            w_daa_byte = r_a[7:0] - w_daa_adj;
        end
        w_daa_res      = r_a;
        w_daa_res[7:0] = w_daa_byte;
        if (r_daa) begin
            w_res   = w_daa_res;
            w_flags = {(w_daa_byte == 8'h00), r_fnhc[2], 1'b0, w_daa_c};
        end
`endif
    end

    // Operand capture at accept, then one nibble per RUN cycle
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= 3'd0;
            r_k   <= '0;
            r_cy  <= 1'b0;
            r_h   <= 1'b0;
            r_acc <= '0;
`ifdef ALU_NIBBLE_DAA_EN
            r_daa  <= 1'b0;
            r_fnhc <= 3'b000;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_k   <= '0;
            r_cy  <= w_cin0;
            r_h   <= 1'b0;
            r_acc <= '0;
`ifdef ALU_NIBBLE_DAA_EN
            r_daa  <= daa;
            r_fnhc <= flags_in[2:0];
`endif
        end else if (r_state == S_RUN) begin
            r_acc <= w_full;
            r_cy  <= w_cout;
            r_k   <= r_k + KW'(1);
            if (r_k == c_K_HALF) r_h <= w_cout;
        end
    end

    // Visible result only changes on the edge that enters DONE
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            res       <= '0;
            flags_out <= 4'b0000;
        end else if ((w_state_nx == S_DONE) && (r_state != S_DONE)) begin
            res       <= w_res;
            flags_out <= w_flags;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_nibble_seq
// Description : Self-checking bench for alu_nibble_seq (WIDTH 8 and 16).
//               Honours ALU_NIBBLE_DAA_EN for latency and DAA vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_nibble_seq;

`ifdef ALU_NIBBLE_DAA_EN
    localparam int LAT8  = 4;
    localparam int LAT16 = 6;
`else
    localparam int LAT8  = 3;
    localparam int LAT16 = 5;
`endif
    localparam int BUSY8 = LAT8 - 1;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        start8, start16;
    logic [2:0]  op;
    logic        daa;
    logic [3:0]  flags_in;
    logic [7:0]  a8, b8, res8;
    logic [15:0] a16, b16, res16;
    logic        busy8, done8, busy16, done16;
    logic [3:0]  flags8, flags16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    alu_nibble_seq #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .nRESET(nRESET), .start(start8), .op(op), .daa(daa),
        .a(a8), .b(b8), .flags_in(flags_in),
        .busy(busy8), .done(done8), .res(res8), .flags_out(flags8)
    );

    alu_nibble_seq #(.WIDTH(16)) u_dut16 (
        .CLK(CLK), .nRESET(nRESET), .start(start16), .op(op), .daa(daa),
        .a(a16), .b(b16), .flags_in(flags_in),
        .busy(busy16), .done(done16), .res(res16), .flags_out(flags16)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from arithmetic rules: returns {Z,N,H,C, result[31:0]}
    function automatic logic [35:0] ref_alu(input int w, input logic [2:0] o,
                                            input logic d, input logic [31:0] ai,
                                            input logic [31:0] bi, input logic [3:0] f);
        longint m  = (longint'(1) << w) - 1;
        longint hm = (longint'(1) << (w - 4)) - 1;
        longint av = longint'(ai) & m;
        longint bv = longint'(bi) & m;
        longint c  = 0;
        longint r  = 0;
        logic z, n, h, cy;
        n = 1'b0; h = 1'b0; cy = 1'b0;
`ifdef ALU_NIBBLE_DAA_EN
        if (d) begin
            longint lo = av & 255;
            longint adj = 0;
            if (!f[2]) begin
                if (f[1] || (lo & 15) > 9) adj += 6;
                cy = f[0] || (lo > 153);
                if (cy) adj += 96;
                lo = (lo + adj) & 255;
            end else begin
                if (f[1]) adj += 6;
                if (f[0]) adj += 96;
                cy = f[0];
                lo = (lo - adj) & 255;
            end
            r = (av & ~longint'(255)) | lo;
            return {(lo == 0), f[2], 1'b0, cy, r[31:0]};
        end
`else
        if (d) c = 0;
`endif
        case (o)
            3'd0, 3'd1: begin
                c  = (o == 3'd1) ? longint'(f[0]) : 0;
                r  = av + bv + c;
                cy = (r >> w) != 0;
                h  = (((av & hm) + (bv & hm) + c) >> (w - 4)) != 0;
                r  = r & m;
            end
            3'd2, 3'd3, 3'd7: begin
                c  = (o == 3'd3) ? longint'(f[0]) : 0;
                r  = av - bv - c;
                cy = r < 0;
                h  = ((av & hm) - (bv & hm) - c) < 0;
                n  = 1'b1;
                r  = r & m;
            end
            3'd4: begin r = av & bv; h = 1'b1; end
            3'd5: r = av ^ bv;
            default: r = av | bv;
        endcase
        z = (r == 0);
        if (o == 3'd7) r = av;
        return {z, n, h, cy, r[31:0]};
    endfunction

    // Protocol model of the 8-bit unit: remaining busy cycles and held outputs
    int          m_rem;
    logic        m_done;
    logic [7:0]  m_res;
    logic [3:0]  m_flg;
    logic [35:0] m_pend;

    always @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_res  <= 8'h00;
            m_flg  <= 4'h0;
            m_pend <= '0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend[7:0];
                m_flg  <= m_pend[35:32];
            end
        end else begin
            m_done <= 1'b0;
            if (start8) begin
                m_rem  <= BUSY8;
                m_pend <= ref_alu(8, op, daa, {24'h0, a8}, {24'h0, b8}, flags_in);
            end
        end
    end

    // Every-cycle comparison of the 8-bit unit against the model
    always @(negedge CLK) begin
        if (nRESET) begin
            check("busy8",  busy8,  m_rem > 0);
            check("done8",  done8,  m_done);
            check("res8",   res8,   m_res);
            check("flags8", flags8, m_flg);
        end
    end

    // Issue one 8-bit op from a negedge; returns at the negedge where done=1
    task automatic do_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [3:0] f, input logic d, input bit poke, input bit lit,
                         input logic [7:0] er, input logic [3:0] ef, input string nm);
        int n;
        int bc;
        bit got;
        op = o; a8 = av; b8 = bv; flags_in = f; daa = d; start8 = 1'b1;
        @(posedge CLK);
        n = 1; bc = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge CLK);
            start8 = poke && (n == 2);
            a8 = ~av; b8 = ~bv; flags_in = ~f;
            if (done8) got = 1'b1;
            else begin
                if (busy8) bc++;
                @(posedge CLK);
                n++;
            end
        end
        check({nm, "_done_seen"}, got, 1'b1);
        if (got) begin
            check({nm, "_latency"}, n, LAT8);
            check({nm, "_busy_cycles"}, bc, BUSY8);
            if (lit) begin
                check({nm, "_res"}, res8, er);
                check({nm, "_flags"}, flags8, ef);
            end
        end
    endtask

    task automatic run16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [3:0] ef, input string nm);
        int n;
        bit got;
        op = o; a16 = av; b16 = bv; flags_in = 4'h0; daa = 1'b0; start16 = 1'b1;
        @(posedge CLK);
        n = 1; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge CLK);
            start16 = 1'b0;
            if (done16) got = 1'b1;
            else begin
                @(posedge CLK);
                n++;
            end
        end
        check({nm, "_done_seen"}, got, 1'b1);
        if (got) begin
            check({nm, "_latency"}, n, LAT16);
            check({nm, "_res"}, res16, er);
            check({nm, "_flags"}, flags16, ef);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; start8 = 1'b0; start16 = 1'b0; op = 3'd0; daa = 1'b0;
        flags_in = 4'h0; a8 = 8'h00; b8 = 8'h00; a16 = 16'h0; b16 = 16'h0;
        repeat (3) @(negedge CLK);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_res8", res8, 8'h00);
        check("rst_flags8", flags8, 4'h0);
        check("rst_busy16", busy16, 1'b0);
        check("rst_res16", res16, 16'h0);
        nRESET = 1'b1;
        @(negedge CLK);

        // Directed 8-bit vectors, issued back to back (start lands in DONE)
        do_op(3'd0, 8'h05, 8'h07, 4'h0, 1'b0, 0, 1, 8'h0C, 4'b0000, "add_05_07");
        do_op(3'd0, 8'h0F, 8'h01, 4'h0, 1'b0, 0, 1, 8'h10, 4'b0010, "add_0f_01");
        do_op(3'd0, 8'hFF, 8'h01, 4'h0, 1'b0, 0, 1, 8'h00, 4'b1011, "add_ff_01");
        do_op(3'd3, 8'h10, 8'h01, 4'h1, 1'b0, 0, 1, 8'h0E, 4'b0110, "sbc_10_01");
        do_op(3'd7, 8'h3C, 8'h3C, 4'h0, 1'b0, 0, 1, 8'h3C, 4'b1100, "cp_3c_3c");
        do_op(3'd1, 8'h7F, 8'h00, 4'h1, 1'b0, 1, 1, 8'h80, 4'b0010, "adc_poke");
        do_op(3'd4, 8'hF0, 8'h3C, 4'h0, 1'b0, 0, 1, 8'h30, 4'b0010, "and_f0_3c");
        do_op(3'd5, 8'hA5, 8'hA5, 4'h0, 1'b0, 0, 1, 8'h00, 4'b1000, "xor_a5_a5");
        do_op(3'd6, 8'h50, 8'h05, 4'hF, 1'b0, 0, 1, 8'h55, 4'b0000, "or_50_05");

        // Asynchronous reset while an operation is running
        op = 3'd0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start8 = 1'b0;
        #2 nRESET = 1'b0;
        #1;
        check("midrst_busy8", busy8, 1'b0);
        check("midrst_done8", done8, 1'b0);
        check("midrst_res8", res8, 8'h00);
        check("midrst_flags8", flags8, 4'h0);
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);

        // 16-bit unit
        run16(3'd0, 16'h0FFF, 16'h0001, 16'h1000, 4'b0010, "w16_add");
        run16(3'd2, 16'h1000, 16'h0001, 16'h0FFF, 4'b0110, "w16_sub");
        @(negedge CLK);

        // Cyclic sweep, all ops, checked by the model every cycle
        for (int i = 0; i < 256; i++) begin
            do_op(3'(i % 8), 8'(i), 8'(i * 7 + 3), {i[1], i[5], i[2], i[6]},
                  (i % 5) == 0, 0, 0, 8'h00, 4'h0, "sweep");
        end

`ifdef ALU_NIBBLE_DAA_EN
        do_op(3'd0, 8'h3C, 8'h00, 4'h0, 1'b1, 0, 1, 8'h42, 4'b0000, "daa_3c");
        do_op(3'd0, 8'h9A, 8'h00, 4'h0, 1'b1, 0, 1, 8'h00, 4'b1001, "daa_9a");
`endif

        @(negedge CLK);
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
